// File: rtl/run_ctrl.sv
`timescale 1ns/1ps
// run_ctrl
// Run/reset controller for the pipelined 6502 system. On a start request it
// sequences a staggered per-channel synchronous reset, then runs the core
// while counting cycles and memory stalls. The run ends on a self-loop trap
// (instruction address held constant), a cycle timeout, or an abort.
//
// Ports:
//   clk_i       in   1      clock, rising edge
//   rst_i       in   1      synchronous active-high reset
//   start_i     in   1      start request (IDLE, DONE)
//   abort_i     in   1      abort (PRE, RESET, RUN)
//   stl_i       in   1      memory stall
//   inst_adr_i  in   ADR_W  current instruction address
//   ch_rst_o    out  N_CH   per-channel system reset, active-high
//   run_o       out  1      high in RUN
//   busy_o      out  1      high in PRE, RESET, RUN
//   done_o      out  1      high in DONE
//   trap_o      out  1      run ended by trap
//   timeout_o   out  1      run ended by timeout
//   trap_adr_o  out  ADR_W  trapped address
//   cyc_cnt_o   out  CNT_W  RUN cycle counter
//   stl_cnt_o   out  CNT_W  stalled RUN cycles, saturating
//
// state | meaning
// IDLE  | waiting for start, channels released
// PRE   | delay before reset assertion
// RESET | channels held in reset, released one by one
// RUN   | core running, counters and trap matcher active
// DONE  | run terminated, channels frozen in reset, results held
module run_ctrl #(
  parameter int ADR_W       = 16,
  parameter int CNT_W       = 32,
  parameter int N_CH        = 2,
  parameter int RST_DLY     = 2,
  parameter int RST_LEN     = 3,
  parameter int CH_STAGGER  = 1,
  parameter int TIMEOUT_CYC = 100,
  parameter int TRAP_CYC    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stl_i,
  input  logic [ADR_W-1:0] inst_adr_i,
  output logic [N_CH-1:0]  ch_rst_o,
  output logic             run_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             trap_o,
  output logic             timeout_o,
  output logic [ADR_W-1:0] trap_adr_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] stl_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_RESET = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Total RESET-state cycles: the last channel releases last.
  localparam int RST_TOT = RST_LEN + (N_CH - 1) * CH_STAGGER;
  localparam int M_W     = $clog2(TRAP_CYC + 1);

  logic [2:0]       r_state, w_state_nxt;
  logic [31:0]      r_tmr, w_tmr_nxt;
  logic [N_CH-1:0]  r_ch_rst, w_ch_rst_nxt;
  logic             r_run, r_busy, r_done;
  logic             r_trap, w_trap_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [ADR_W-1:0] r_trap_adr, w_trap_adr_nxt;
  logic [CNT_W-1:0] r_cyc, w_cyc_nxt;
  logic [CNT_W-1:0] r_stl, w_stl_nxt;
  logic [ADR_W-1:0] r_ref, w_ref_nxt;
  logic [M_W-1:0]   r_match, w_match_nxt;
  logic             w_hit_trap, w_hit_to;

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_ch_rst_nxt   = r_ch_rst;
    w_trap_nxt     = r_trap;
    w_timeout_nxt  = r_timeout;
    w_trap_adr_nxt = r_trap_adr;
    w_cyc_nxt      = r_cyc;
    w_stl_nxt      = r_stl;
    w_ref_nxt      = r_ref;
    w_match_nxt    = r_match;
    w_hit_trap     = 1'b0;
    w_hit_to       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_trap_nxt     = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_trap_adr_nxt = '0;
          w_cyc_nxt      = '0;
          w_stl_nxt      = '0;
          if (RST_DLY == 0) begin
            w_state_nxt  = S_RESET;
            w_ch_rst_nxt = {N_CH{1'b1}};
            w_tmr_nxt    = 32'(RST_TOT - 1);
          end else begin
            w_state_nxt  = S_PRE;
            w_ch_rst_nxt = '0;
            w_tmr_nxt    = 32'((RST_DLY > 0) ? RST_DLY - 1 : 0);
          end
        end
      end

      S_PRE: begin
        if (abort_i) begin
          w_state_nxt  = S_IDLE;
          w_ch_rst_nxt = '0;
        end else if (r_tmr == 32'd0) begin
          w_state_nxt  = S_RESET;
          w_ch_rst_nxt = {N_CH{1'b1}};
          w_tmr_nxt    = 32'(RST_TOT - 1);
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
      end

      S_RESET: begin
        if (abort_i) begin
          w_state_nxt  = S_IDLE;
          w_ch_rst_nxt = '0;
        end else begin
          // r_tmr counts remaining RESET cycles after this one; channel k
          // stays asserted while more than its stagger slack remains.
          for (int k = 0; k < N_CH; k++) begin
            w_ch_rst_nxt[k] = (r_tmr > 32'((N_CH - 1 - k) * CH_STAGGER));
          end
          if (r_tmr == 32'd0) begin
            w_state_nxt = S_RUN;
            w_match_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr - 32'd1;
          end
        end
      end

      S_RUN: begin
        if (abort_i) begin
          w_state_nxt  = S_IDLE;
          w_ch_rst_nxt = '0;
        end else begin
          if (stl_i && (r_stl != {CNT_W{1'b1}})) begin
            w_stl_nxt = r_stl + 1'b1;
          end

          // A zero match count marks the first RUN cycle: always load.
          if (r_match == '0) begin
            w_ref_nxt   = inst_adr_i;
            w_match_nxt = M_W'(1);
          end else if (!stl_i) begin
            if (inst_adr_i == r_ref) begin
              w_match_nxt = r_match + 1'b1;
            end else begin
              w_ref_nxt   = inst_adr_i;
              w_match_nxt = M_W'(1);
            end
          end

          w_hit_trap = (w_match_nxt == M_W'(TRAP_CYC));
          w_hit_to   = (r_cyc == CNT_W'(TIMEOUT_CYC - 1));

          // The deciding cycle does not advance the cycle counter, so it
          // freezes at the count of the cycle that ended the run.
          if (w_hit_trap) begin
            w_state_nxt    = S_DONE;
            w_trap_nxt     = 1'b1;
            w_trap_adr_nxt = w_ref_nxt;
            w_ch_rst_nxt   = {N_CH{1'b1}};
          end else if (w_hit_to) begin
            w_state_nxt    = S_DONE;
            w_timeout_nxt  = 1'b1;
            w_ch_rst_nxt   = {N_CH{1'b1}};
          end else begin
            w_cyc_nxt = r_cyc + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_ch_rst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_ch_rst   <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_trap     <= 1'b0;
      r_timeout  <= 1'b0;
      r_trap_adr <= '0;
      r_cyc      <= '0;
      r_stl      <= '0;
      r_ref      <= '0;
      r_match    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_ch_rst   <= w_ch_rst_nxt;
      r_run      <= (w_state_nxt == S_RUN);
      r_busy     <= (w_state_nxt == S_PRE) || (w_state_nxt == S_RESET) ||
                    (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      r_trap     <= w_trap_nxt;
      r_timeout  <= w_timeout_nxt;
      r_trap_adr <= w_trap_adr_nxt;
      r_cyc      <= w_cyc_nxt;
      r_stl      <= w_stl_nxt;
      r_ref      <= w_ref_nxt;
      r_match    <= w_match_nxt;
    end
  end

  assign ch_rst_o   = r_ch_rst;
  assign run_o      = r_run;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign trap_o     = r_trap;
  assign timeout_o  = r_timeout;
  assign trap_adr_o = r_trap_adr;
  assign cyc_cnt_o  = r_cyc;
  assign stl_cnt_o  = r_stl;

endmodule

// File: tb/tb_run_ctrl.sv
`timescale 1ns/1ps
// tb_run_ctrl
// Directed bench for run_ctrl: a vector table for the start/reset sequence,
// plus hand-written sequences for trap, stall, timeout, abort, reset and
// the trap-versus-timeout tie (second instance with TIMEOUT_CYC=TRAP_CYC=4).
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, start2, abort, stl;
  logic [15:0] adr;

  logic [1:0]  ch_rst;
  logic        run, busy, done, trap, tmo;
  logic [15:0] trap_adr;
  logic [31:0] cyc, stl_cnt;

  logic [1:0]  ch_rst2;
  logic        run2, busy2, done2, trap2, tmo2;
  logic [15:0] trap_adr2;
  logic [31:0] cyc2, stl_cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .stl_i(stl),
    .inst_adr_i(adr), .ch_rst_o(ch_rst), .run_o(run), .busy_o(busy),
    .done_o(done), .trap_o(trap), .timeout_o(tmo), .trap_adr_o(trap_adr),
    .cyc_cnt_o(cyc), .stl_cnt_o(stl_cnt)
  );

  run_ctrl #(.TIMEOUT_CYC(4), .TRAP_CYC(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort), .stl_i(stl),
    .inst_adr_i(adr), .ch_rst_o(ch_rst2), .run_o(run2), .busy_o(busy2),
    .done_o(done2), .trap_o(trap2), .timeout_o(tmo2), .trap_adr_o(trap_adr2),
    .cyc_cnt_o(cyc2), .stl_cnt_o(stl_cnt2)
  );

  typedef struct {
    logic        start;
    logic [15:0] adr;
    logic [1:0]  ch;
    logic        run;
    logic        busy;
    logic        done;
    logic        trap;
    logic        tmo;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector i drives the inputs of cycle i (start in cycle 0) and checks the
  // registered outputs of cycle i+1.
  task automatic apply_table(input int n);
    for (int i = 0; i < n; i++) begin
      start = tbl[i].start;
      adr   = tbl[i].adr;
      tick();
      chk($sformatf("vec%0d ch_rst", i), 64'(ch_rst), 64'(tbl[i].ch));
      chk($sformatf("vec%0d run", i),    64'(run),    64'(tbl[i].run));
      chk($sformatf("vec%0d busy", i),   64'(busy),   64'(tbl[i].busy));
      chk($sformatf("vec%0d done", i),   64'(done),   64'(tbl[i].done));
      chk($sformatf("vec%0d trap", i),   64'(trap),   64'(tbl[i].trap));
      chk($sformatf("vec%0d timeout", i), 64'(tmo),   64'(tbl[i].tmo));
      chk($sformatf("vec%0d cyc", i),    64'(cyc),    64'(tbl[i].cyc));
    end
    start = 1'b0;
  endtask

  function automatic logic [15:0] trap_adr_seq(input int c);
    return (c < 10) ? 16'(16'h03F6 + c) : 16'h0400;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              start adr       ch     run   busy  done  trap  tmo   cyc
    tbl[0] = '{1'b1, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[3] = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[4] = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[6] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[7] = '{1'b0, 16'h03F6, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; stl = 1'b0; adr = '0;
    tick();
    tick();
    chk("rst ch_rst",   64'(ch_rst),   64'd0);
    chk("rst run",      64'(run),      64'd0);
    chk("rst busy",     64'(busy),     64'd0);
    chk("rst done",     64'(done),     64'd0);
    chk("rst trap",     64'(trap),     64'd0);
    chk("rst timeout",  64'(tmo),      64'd0);
    chk("rst trap_adr", 64'(trap_adr), 64'd0);
    chk("rst cyc",      64'(cyc),      64'd0);
    chk("rst stl",      64'(stl_cnt),  64'd0);
    rst = 1'b0;
    tick();

    // Start from IDLE; then address walks up and holds 0x0400 from cyc 10.
    apply_table(8);
    for (int c = 1; c <= 12; c++) begin
      adr = trap_adr_seq(c);
      tick();
    end
    chk("trap pre done", 64'(done), 64'd0);
    chk("trap pre cyc",  64'(cyc),  64'd13);
    adr = trap_adr_seq(13);
    tick();
    chk("trap done",     64'(done),     64'd1);
    chk("trap run",      64'(run),      64'd0);
    chk("trap busy",     64'(busy),     64'd0);
    chk("trap flag",     64'(trap),     64'd1);
    chk("trap timeout",  64'(tmo),      64'd0);
    chk("trap adr",      64'(trap_adr), 64'h0400);
    chk("trap cyc",      64'(cyc),      64'd13);
    chk("trap ch_rst",   64'(ch_rst),   64'h3);
    tick();
    chk("done hold cyc", 64'(cyc),      64'd13);
    chk("done hold trap", 64'(trap),    64'd1);

    // Restart from DONE (table checks cleared flags and PRE timing); stall
    // five cycles during the hold.
    apply_table(8);
    for (int c = 1; c <= 17; c++) begin
      adr = trap_adr_seq(c);
      stl = (c >= 11 && c <= 15);
      tick();
    end
    stl = 1'b0;
    chk("stall pre done", 64'(done), 64'd0);
    chk("stall pre cyc",  64'(cyc),  64'd18);
    adr = trap_adr_seq(18);
    tick();
    chk("stall done",    64'(done),     64'd1);
    chk("stall trap",    64'(trap),     64'd1);
    chk("stall adr",     64'(trap_adr), 64'h0400);
    chk("stall stl_cnt", 64'(stl_cnt),  64'd5);
    chk("stall cyc",     64'(cyc),      64'd18);

    // Address changes every cycle; a start pulse mid-run must be ignored.
    apply_table(8);
    chk("restart stl_cnt", 64'(stl_cnt), 64'd0);
    for (int c = 1; c <= 98; c++) begin
      adr   = 16'(c);
      start = (c == 50);
      tick();
    end
    start = 1'b0;
    chk("tmo pre done", 64'(done), 64'd0);
    chk("tmo pre cyc",  64'(cyc),  64'd99);
    adr = 16'd99;
    tick();
    chk("tmo done",    64'(done), 64'd1);
    chk("tmo flag",    64'(tmo),  64'd1);
    chk("tmo trap",    64'(trap), 64'd0);
    chk("tmo cyc",     64'(cyc),  64'd99);
    tick();
    chk("tmo hold cyc", 64'(cyc), 64'd99);

    // Abort during RESET.
    apply_table(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort rst ch_rst", 64'(ch_rst), 64'd0);
    chk("abort rst busy",   64'(busy),   64'd0);
    chk("abort rst run",    64'(run),    64'd0);
    chk("abort rst done",   64'(done),   64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort idle busy",  64'(busy),   64'd0);

    // rst_i mid-RUN, then the cycle-0 sequence again.
    apply_table(8);
    adr = 16'h1000; tick();
    adr = 16'h1001; tick();
    chk("mid run cyc", 64'(cyc), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ch_rst", 64'(ch_rst), 64'd0);
    chk("midrst run",    64'(run),    64'd0);
    chk("midrst busy",   64'(busy),   64'd0);
    chk("midrst cyc",    64'(cyc),    64'd0);
    apply_table(8);

    // Abort during RUN.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort run run",    64'(run),    64'd0);
    chk("abort run busy",   64'(busy),   64'd0);
    chk("abort run ch_rst", 64'(ch_rst), 64'd0);

    // Trap and timeout in the same cycle on the second instance.
    adr = 16'h1234;
    begin
      int n;
      n = 0;
      start2 = 1'b1;
      tick();
      n++;
      start2 = 1'b0;
      while (!done2 && n < 30) begin
        tick();
        n++;
      end
      chk("tie latency",  64'(n),         64'd11);
      chk("tie done",     64'(done2),     64'd1);
      chk("tie trap",     64'(trap2),     64'd1);
      chk("tie timeout",  64'(tmo2),      64'd0);
      chk("tie adr",      64'(trap_adr2), 64'h1234);
      chk("tie cyc",      64'(cyc2),      64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run/reset controller for the pipelined 6502 system, sitting between the bench or board and the `System` instance. On request it:

- sequences a per-channel synchronous reset with programmable delay, length and stagger;
- runs the core while counting cycles and memory stalls;
- terminates the run on a self-loop trap (instruction address held constant), a cycle timeout, or an abort.

It generalises the fixed-timing clock/reset/stop sequencing used in simulation into reusable, synthesizable RTL with run-termination detection.

## Interface
Parameters:
- `ADR_W`, 16, instruction address width.
- `CNT_W`, 32, cycle and stall counter width.
- `N_CH`, 2, number of reset channels (≥1).
- `RST_DLY`, 2, cycles in PRE before reset assertion (≥0).
- `RST_LEN`, 3, cycles channel 0 is held in reset (≥1).
- `CH_STAGGER`, 1, extra hold cycles per channel index (≥0).
- `TIMEOUT_CYC`, 100, RUN cycles before timeout (≥1, < 2^CNT_W).
- `TRAP_CYC`, 4, consecutive non-stalled equal-address samples that declare a trap (≥2).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  start request; sampled in IDLE and DONE.
- `abort_i`  in  1  abort; sampled in PRE, RESET and RUN.
- `stl_i`  in  1  memory stall from the memory unit.
- `inst_adr_i`  in  ADR_W  current instruction address from the core.
- `ch_rst_o`  out  N_CH  per-channel system reset, active-high.
- `run_o`  out  1  high in RUN.
- `busy_o`  out  1  high in PRE, RESET and RUN.
- `done_o`  out  1  high in DONE.
- `trap_o`  out  1  DONE caused by trap.
- `timeout_o`  out  1  DONE caused by timeout.
- `trap_adr_o`  out  ADR_W  address that trapped.
- `cyc_cnt_o`  out  CNT_W  RUN cycle counter.
- `stl_cnt_o`  out  CNT_W  stalled RUN cycles, saturating.

## Operation
- FSM states: IDLE, PRE, RESET, RUN, DONE. All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE. This applies mid-operation: `rst_i` overrides everything at the next edge.
- IDLE:
  - `ch_rst_o`=0.
  - `start_i` → PRE, or → RESET directly if RST_DLY=0.
- PRE: counts RST_DLY cycles → RESET.
- RESET:
  - On entry, `ch_rst_o` = all ones.
  - Channel k deasserts after RST_LEN + k·CH_STAGGER RESET cycles.
  - → RUN in the cycle the last channel deasserts.
- RUN: each cycle, `cyc_cnt_o`++ (wraps modulo 2^CNT_W, unreachable given the TIMEOUT_CYC bound).
- Stalls: if `stl_i`, `stl_cnt_o`++ (saturating at all ones) and the trap matcher holds.
- Trap matcher:
  - First RUN cycle: load the reference address, match count = 1.
  - Each later non-stalled cycle: equal address → count++; different address → reload reference, count = 1.
  - Count reaching TRAP_CYC → DONE, `trap_o`=1, `trap_adr_o`=reference.
- Timeout: RUN cycle with `cyc_cnt_o`==TIMEOUT_CYC−1 → DONE, `timeout_o`=1.
- Simultaneous trap and timeout: trap wins (`trap_o`=1, `timeout_o`=0).
- DONE:
  - `ch_rst_o` = all ones (system frozen).
  - Counters, flags and `trap_adr_o` hold.
  - `start_i` → PRE/RESET, clearing counters and flags on that transition.
- `abort_i` in PRE/RESET/RUN → IDLE next cycle. All flags and counters hold their last values until the next start.
- `start_i` is ignored while `busy_o`. `abort_i` is ignored in IDLE and DONE.

## Timing
- `start_i` high in IDLE at cycle t:
  - PRE occupies t+1 … t+RST_DLY.
  - `ch_rst_o` = all ones at t+1+RST_DLY.
  - Channel k low at t+1+RST_DLY+RST_LEN+k·CH_STAGGER.
  - `run_o` rises the same cycle the last channel goes low, with `cyc_cnt_o`=0.
- Termination to `done_o`: 1 cycle after the deciding RUN cycle; `run_o` falls in the same cycle.
- `trap_o`/`timeout_o` rise together with `done_o`.
- Abort: `busy_o`, `run_o` and `ch_rst_o` are all 0 one cycle after `abort_i`.

## Test plan
- Defaults, `start_i` at cycle 0:
  - PRE at 1–2; `ch_rst_o`=2'b11 at 3; `ch_rst_o`[0] low at 6; `ch_rst_o`[1] low and `run_o`=1 at 7.
  - `cyc_cnt_o` is 0 at cycle 7.
- Address increments, then holds 0x0400 from `cyc_cnt_o`=10, no stalls:
  - `done_o`=`trap_o`=1 in the next cycle after `cyc_cnt_o`=13; `trap_adr_o`=0x0400, `timeout_o`=0.
- Same as above, with `stl_i` high for 5 cycles during the hold:
  - Trap is delayed by exactly 5 cycles; `stl_cnt_o`=5.
- Address changes every cycle:
  - `done_o`=`timeout_o`=1 with `cyc_cnt_o` frozen at 99; `trap_o`=0.
- `abort_i` during RESET:
  - Next cycle IDLE, `ch_rst_o`=0, `busy_o`=0.
- `rst_i` asserted mid-RUN:
  - All outputs 0 next cycle; a subsequent `start_i` repeats the cycle-0 sequence.
- TIMEOUT_CYC=TRAP_CYC=4, constant address:
  - Trap and timeout occur in the same cycle → `trap_o`=1, `timeout_o`=0.
- `start_i` in DONE:
  - Flags and counters clear; sequence restarts with PRE timing as in the first scenario.
